// File: rtl/peak_frame_tx.sv
// Peak frame transmitter.
// Serialises one captured set of 9-bit peaks into a byte frame for a UART:
// header, sequence number, two bytes per peak (high bit first) and an XOR
// checksum. A one-deep pending slot absorbs a peak set arriving mid-frame;
// anything beyond that is dropped and flagged on the sticky overrun output.
module peak_frame_tx #(
  parameter int          MAXIMAS_COUNT = 11,
  parameter logic [7:0]  HEADER_BYTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] peaks_in [MAXIMAS_COUNT],
  input  logic       peaks_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int IDX_W = (MAXIMAS_COUNT > 1) ? $clog2(MAXIMAS_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAXIMAS_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SEQ,
    PEAK_HI,
    PEAK_LO,
    CHECKSUM
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [8:0]       r_active  [MAXIMAS_COUNT];
  logic [8:0]       r_pending [MAXIMAS_COUNT];
  logic             r_pendFull;
  logic             r_overrun;
  logic [7:0]       r_seq;
  logic [7:0]       r_csum;
  logic [IDX_W-1:0] r_peakIdx;

  logic             w_xfer;
  logic             w_ckXfer;
  logic             w_lastPeak;
  logic             w_startIdle;
  logic             w_loadPend;
  logic             w_loadNew;
  logic             w_storePend;
  logic             w_drop;
  logic [8:0]       w_curPeak;

  // A byte leaves only when we present one and the sink takes it.
  assign w_xfer      = (r_state != IDLE) && tx_ready;
  assign w_ckXfer    = (r_state == CHECKSUM) && tx_ready;
  assign w_lastPeak  = (r_peakIdx == LAST_IDX);

  // Frame starts: fresh set while idle, queued set after a checksum, or a
  // fresh set arriving exactly as the checksum leaves with nothing queued.
  assign w_startIdle = (r_state == IDLE) && peaks_valid;
  assign w_loadPend  = w_ckXfer && r_pendFull;
  assign w_loadNew   = w_startIdle || (w_ckXfer && !r_pendFull && peaks_valid);

  // A set arriving mid-frame is queued if the slot is free, otherwise lost.
  // The checksum-accept cycle with a free slot is handled by w_loadNew.
  assign w_storePend = peaks_valid && (r_state != IDLE) && !r_pendFull && !w_ckXfer;
  assign w_drop      = peaks_valid && (r_state != IDLE) && r_pendFull;

  assign w_curPeak   = r_active[r_peakIdx];

  // State register, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: every non-idle state advances only on a transfer.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (peaks_valid) w_nextState = HEADER;
      end
      HEADER: begin
        if (tx_ready) w_nextState = SEQ;
      end
      SEQ: begin
        if (tx_ready) w_nextState = PEAK_HI;
      end
      PEAK_HI: begin
        if (tx_ready) w_nextState = PEAK_LO;
      end
      PEAK_LO: begin
        if (tx_ready) w_nextState = w_lastPeak ? CHECKSUM : PEAK_HI;
      end
      CHECKSUM: begin
        if (tx_ready) w_nextState = (r_pendFull || peaks_valid) ? HEADER : IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output byte mux; driven purely from registered state so it holds while stalled.
  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      HEADER:   tx_data = HEADER_BYTE;
      SEQ:      tx_data = r_seq;
      PEAK_HI:  tx_data = {7'b0, w_curPeak[8]};
      PEAK_LO:  tx_data = w_curPeak[7:0];
      CHECKSUM: tx_data = r_csum;
      default:  tx_data = 8'h00;
    endcase
  end

  assign tx_valid   = (r_state != IDLE);
  assign busy       = (r_state != IDLE);
  assign frame_done = w_ckXfer;
  assign overrun    = r_overrun;

  // Peak index walks the active buffer once per PEAK_LO transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_peakIdx <= '0;
    end else if (w_xfer && (r_state == PEAK_LO)) begin
      r_peakIdx <= w_lastPeak ? '0 : r_peakIdx + 1'b1;
    end
  end

  // Sequence number advances once per completed frame, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seq <= 8'h00;
    end else if (w_ckXfer) begin
      r_seq <= r_seq + 8'h01;
    end
  end

  // Checksum starts at the header value, so only bytes after the header fold in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_csum <= 8'h00;
    end else if (w_loadNew || w_loadPend) begin
      r_csum <= HEADER_BYTE;
    end else if (w_xfer && ((r_state == SEQ) || (r_state == PEAK_HI) || (r_state == PEAK_LO))) begin
      r_csum <= r_csum ^ tx_data;
    end
  end

  // Active buffer snapshot: later input changes never reach a captured frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAXIMAS_COUNT; i++) r_active[i] <= 9'h000;
    end else if (w_loadPend) begin
      r_active <= r_pending;
    end else if (w_loadNew) begin
      r_active <= peaks_in;
    end
  end

  // Pending slot contents, written only when the slot is free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAXIMAS_COUNT; i++) r_pending[i] <= 9'h000;
    end else if (w_storePend) begin
      r_pending <= peaks_in;
    end
  end

  // Pending slot occupancy: emptied when its set becomes the active frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pendFull <= 1'b0;
    end else if (w_loadPend) begin
      r_pendFull <= 1'b0;
    end else if (w_storePend) begin
      r_pendFull <= 1'b1;
    end
  end

  // Sticky overrun flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_peak_frame_tx.sv
// Self-checking bench for peak_frame_tx.
// Expected frame bytes are built from the stimulus and queued on a scoreboard;
// each scenario task drains the queue as the DUT transfers bytes.
module tb_peak_frame_tx;

  localparam int         NPK = 11;
  localparam logic [7:0] HDR = 8'hA5;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [8:0] peaks_in [NPK];
  logic       peaks_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  exp_t       sb[$];
  int         vectors;
  int         errors;
  logic [7:0] expSeq;

  peak_frame_tx #(
    .MAXIMAS_COUNT(NPK),
    .HEADER_BYTE  (HDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .peaks_in   (peaks_in),
    .peaks_valid(peaks_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario loses sync with the DUT.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Queue the expected bytes of one frame; checksum is XOR of all earlier bytes.
  task automatic pushFrame(input logic [8:0] p [NPK]);
    logic [7:0] x;
    exp_t       e;
    x = 8'h00;
    e.last = 1'b0;
    e.data = HDR;                 sb.push_back(e); x ^= e.data;
    e.data = expSeq;              sb.push_back(e); x ^= e.data;
    for (int i = 0; i < NPK; i++) begin
      e.data = {7'b0, p[i][8]};   sb.push_back(e); x ^= e.data;
      e.data = p[i][7:0];         sb.push_back(e); x ^= e.data;
    end
    e.data = x;
    e.last = 1'b1;
    sb.push_back(e);
    expSeq = expSeq + 8'h01;
  endtask

  // One-cycle peaks_valid pulse; entered and left at posedge+1.
  task automatic pulsePeaks(input logic [8:0] p [NPK]);
    peaks_in    = p;
    peaks_valid = 1'b1;
    @(posedge clk); #1;
    peaks_valid = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset  = 1'b1;
    expSeq = 8'h00;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [8:0] z [NPK];
    for (int i = 0; i < NPK; i++) z[i] = 9'h155;
    reset       = 1'b0;
    tx_ready    = 1'b0;
    peaks_in    = z;
    peaks_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
        frame_done !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b data=%h busy=%b done=%b ovr=%b, want 0/00/0/0/0",
               tx_valid, tx_data, busy, frame_done, overrun);
    end
    @(posedge clk); #1;
    reset       = 1'b1;
    peaks_valid = 1'b0;
    expSeq      = 8'h00;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pulse_ignored: got busy=%b valid=%b, want 0/0", busy, tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_frames();
    logic [8:0] z [NPK];
    exp_t       e;
    int         cyc;
    for (int i = 0; i < NPK; i++) z[i] = 9'h000;
    tx_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      pushFrame(z);
      pulsePeaks(z);
      cyc = 0;
      while (sb.size() != 0 && cyc < 100) begin
        @(negedge clk);
        vectors++;
        if (tx_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL zero_gap: got tx_valid=%b, want 1", tx_valid);
        end else begin
          e = sb.pop_front();
          if (tx_data !== e.data || frame_done !== e.last) begin
            errors++;
            $display("[TB] FAIL zero_byte: got data=%h done=%b, want data=%h done=%b",
                     tx_data, frame_done, e.data, e.last);
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
      if (sb.size() != 0) begin
        errors++;
        $display("[TB] FAIL zero_timeout: %0d bytes still expected, want 0", sb.size());
        sb.delete();
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL zero_idle: got busy=%b valid=%b, want 0/0", busy, tx_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_peak_max();
    logic [8:0] p [NPK];
    exp_t       e;
    int         cyc;
    applyReset();
    for (int i = 0; i < NPK; i++) p[i] = 9'h000;
    p[0]     = 9'h1FF;
    tx_ready = 1'b1;
    pushFrame(p);
    pulsePeaks(p);
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL max_gap: got tx_valid=%b, want 1", tx_valid);
      end else begin
        e = sb.pop_front();
        if (tx_data !== e.data || frame_done !== e.last) begin
          errors++;
          $display("[TB] FAIL max_byte: got data=%h done=%b, want data=%h done=%b",
                   tx_data, frame_done, e.data, e.last);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL max_timeout: %0d bytes still expected, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_random_ready();
    logic [8:0] p [NPK];
    exp_t       e;
    int         cyc;
    logic       stall;
    logic [7:0] held;
    applyReset();
    for (int i = 0; i < NPK; i++) p[i] = 9'h000;
    p[0]     = 9'h1FF;
    tx_ready = 1'b0;
    pushFrame(p);
    pulsePeaks(p);
    stall = 1'b0;
    held  = 8'h00;
    cyc   = 0;
    while (sb.size() != 0 && cyc < 600) begin
      @(negedge clk);
      if (stall) begin
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== held) begin
          errors++;
          $display("[TB] FAIL rand_hold: got valid=%b data=%h, want 1/%h", tx_valid, tx_data, held);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        e = sb.pop_front();
        vectors++;
        if (tx_data !== e.data || frame_done !== e.last) begin
          errors++;
          $display("[TB] FAIL rand_byte: got data=%h done=%b, want data=%h done=%b",
                   tx_data, frame_done, e.data, e.last);
        end
      end
      stall = (tx_valid === 1'b1) && !tx_ready;
      held  = tx_data;
      @(posedge clk); #1;
      tx_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_timeout: %0d bytes still expected, want 0", sb.size());
      sb.delete();
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    logic [8:0] a [NPK];
    logic [8:0] b [NPK];
    logic [8:0] c [NPK];
    logic [8:0] junk [NPK];
    exp_t       e;
    int         cyc;
    for (int i = 0; i < NPK; i++) begin
      a[i] = 9'(i * 37 + 5);
      b[i] = 9'(9'h1F0 - i * 13);
      c[i] = 9'h0AA;
    end
    tx_ready = 1'b0;
    pushFrame(a);
    pushFrame(b);
    pulsePeaks(a);
    @(posedge clk); #1;
    pulsePeaks(b);
    @(posedge clk); #1;
    pulsePeaks(c);
    for (int i = 0; i < NPK; i++) junk[i] = 9'($urandom);
    peaks_in = junk;
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b1 || busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== HDR) begin
      errors++;
      $display("[TB] FAIL ovr_flag: got ovr=%b busy=%b valid=%b data=%h, want 1/1/1/%h",
               overrun, busy, tx_valid, tx_data, HDR);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ovr_gap: got tx_valid=%b, want 1", tx_valid);
      end else begin
        e = sb.pop_front();
        if (tx_data !== e.data || frame_done !== e.last) begin
          errors++;
          $display("[TB] FAIL ovr_byte: got data=%h done=%b, want data=%h done=%b",
                   tx_data, frame_done, e.data, e.last);
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NPK; i++) junk[i] = 9'($urandom);
      peaks_in = junk;
      cyc++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL ovr_timeout: %0d bytes still expected, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovr_dropped: got busy=%b ovr=%b, want 0/1", busy, overrun);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [8:0] x [NPK];
    logic [8:0] y [NPK];
    exp_t       e;
    int         cyc;
    logic       armed;
    for (int i = 0; i < NPK; i++) begin
      x[i] = 9'(i * 51 + 3);
      y[i] = 9'(9'h100 | (i * 7));
    end
    tx_ready = 1'b1;
    pushFrame(x);
    pulsePeaks(x);
    armed = 1'b1;
    cyc   = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_gap: got tx_valid=%b, want 1", tx_valid);
      end else begin
        e = sb.pop_front();
        if (tx_data !== e.data || frame_done !== e.last) begin
          errors++;
          $display("[TB] FAIL b2b_byte: got data=%h done=%b, want data=%h done=%b",
                   tx_data, frame_done, e.data, e.last);
        end
      end
      @(posedge clk); #1;
      peaks_valid = 1'b0;
      if (armed && sb.size() == 1) begin
        pushFrame(y);
        peaks_in    = y;
        peaks_valid = 1'b1;
        armed       = 1'b0;
      end
      cyc++;
    end
    peaks_valid = 1'b0;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: %0d bytes still expected, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] p [NPK];
    exp_t       e;
    int         cyc;
    for (int i = 0; i < NPK; i++) p[i] = 9'(i * 29 + 100);
    tx_ready = 1'b1;
    pulsePeaks(p);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_active: got tx_valid=%b before reset edge, want 1", tx_valid);
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
        tx_data !== 8'h00 || frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got valid=%b busy=%b ovr=%b data=%h done=%b, want 0/0/0/00/0",
               tx_valid, busy, overrun, tx_data, frame_done);
    end
    @(posedge clk); #1;
    reset  = 1'b1;
    expSeq = 8'h00;
    sb.delete();
    pushFrame(p);
    pulsePeaks(p);
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mid_gap: got tx_valid=%b, want 1", tx_valid);
      end else begin
        e = sb.pop_front();
        if (tx_data !== e.data || frame_done !== e.last) begin
          errors++;
          $display("[TB] FAIL mid_byte: got data=%h done=%b, want data=%h done=%b",
                   tx_data, frame_done, e.data, e.last);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_timeout: %0d bytes still expected, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Scenario sequence.
  initial begin
    vectors     = 0;
    errors      = 0;
    expSeq      = 8'h00;
    reset       = 1'b0;
    peaks_valid = 1'b0;
    tx_ready    = 1'b0;
    for (int i = 0; i < NPK; i++) peaks_in[i] = 9'h000;
    @(posedge clk); #1;
    test_reset();
    test_zero_frames();
    test_peak_max();
    test_random_ready();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/peak_frame_tx.md
PEAK_FRAME_TX -- requirements
Module: peak_frame_tx

Interface
REQ-001 Parameter MAXIMAS_COUNT, default 11, number of 9-bit peaks per frame.
REQ-002 Parameter HEADER_BYTE, default 8'hA5, frame start marker.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 peaks_in  input  9 x MAXIMAS_COUNT (unpacked array)  peak values from the peak finder; element 0 is sent first.
REQ-006 peaks_valid  input  1  single-cycle pulse; peaks_in is valid in this cycle only.
REQ-007 tx_ready  input  1  downstream byte sink (UART transmitter) accepts tx_data.
REQ-008 tx_data  output  8  current frame byte.
REQ-009 tx_valid  output  1  tx_data is valid.
REQ-010 busy  output  1  a frame is being transmitted.
REQ-011 frame_done  output  1  single-cycle pulse when the checksum byte is accepted.
REQ-012 overrun  output  1  sticky flag: a peak set was dropped.

Function
REQ-013 Frame format, in order: HEADER_BYTE; seq (8-bit frame counter); for each peak i = 0..MAXIMAS_COUNT-1, {7'b0, peak[8]} then peak[7:0]; checksum = XOR of all preceding frame bytes; 2*MAXIMAS_COUNT+3 bytes total (25 at default).
REQ-014 States: IDLE, HEADER, SEQ, PEAK_HI, PEAK_LO, CHECKSUM; a peak index counter selects the element in PEAK_HI/PEAK_LO.
REQ-015 A byte transfer occurs only in a cycle with tx_valid=1 and tx_ready=1; otherwise tx_data and tx_valid hold unchanged.
REQ-016 tx_valid=1 in every non-IDLE state; tx_valid=0 in IDLE.
REQ-017 Transitions on transfer: HEADER->SEQ->PEAK_HI->PEAK_LO; PEAK_LO->PEAK_HI with index+1 if index<MAXIMAS_COUNT-1, else PEAK_LO->CHECKSUM; CHECKSUM->IDLE, or ->HEADER if the pending slot is full.
REQ-018 peaks_valid in IDLE at cycle T copies peaks_in into the active buffer; at T+1 the state is HEADER, tx_valid=1, and tx_data=HEADER_BYTE.
REQ-019 Checksum accumulator is loaded with HEADER_BYTE on frame start and XORs each transferred byte; CHECKSUM state presents the accumulated value.
REQ-020 busy=1 whenever the state is not IDLE.
REQ-021 frame_done=1 for exactly the cycle in which the checksum byte transfers.
REQ-022 seq increments by 1 on each frame_done; it wraps 8'hFF->8'h00.
REQ-023 One-deep pending slot: peaks_valid while not IDLE stores peaks_in into pending if empty.
REQ-024 peaks_valid while not IDLE with pending already full drops the new set, keeps pending unchanged, and sets overrun=1.
REQ-025 On checksum transfer with pending full, pending moves to the active buffer and is marked empty; the next cycle is HEADER, with no IDLE gap.
REQ-026 peaks_valid in the same cycle as the checksum transfer, with pending empty, is captured as the next frame; the next cycle is HEADER.
REQ-027 Input snapshot: later changes on peaks_in never alter a frame already captured.
REQ-028 overrun clears only on reset.

Reset
REQ-029 reset=0 at a clock edge forces IDLE and all of the following, regardless of state, including mid-frame: tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, overrun=0, seq=0, pending empty, index=0.
REQ-030 A peaks_valid pulse coincident with active reset is ignored.

Verification
REQ-031 tx_ready=1 always, all peaks 0, one pulse: 25 bytes A5,00,00 x22,A5 on consecutive cycles; frame_done on byte 25; a second frame gives seq=01 and checksum A4.
REQ-032 peak[0]=9'h1FF, others 0, seq=0: bytes A5,00,01,FF,00 x20,5B.
REQ-033 tx_ready toggled randomly: tx_data and tx_valid stay stable while tx_ready=0; the byte sequence is identical to REQ-032.
REQ-034 tx_ready=0; three peaks_valid pulses while busy: the second set is sent after the first frame with no IDLE cycle, the third set is dropped, and overrun=1.
REQ-035 peaks_valid in the checksum-accept cycle: HEADER follows next cycle; the new frame carries the incremented seq.
REQ-036 reset=0 during byte 10: next cycle tx_valid=0, busy=0, overrun=0; after release, the next frame starts with seq=00.
